// File: rtl/store_trace_checker.sv
// Store-stream checker: compares snooped data-memory stores, in order,
// against a loadable table of expected (address, data) pairs.
module store_trace_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter int FILTER  = 0,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] win_lo,
    input  logic [ADDR_W-1:0] win_hi,
    input  logic              tbl_we,
    input  logic [IW-1:0]     tbl_idx,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic [CW-1:0]     exp_count,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [CW-1:0]     match_cnt,
    output logic [ADDR_W-1:0] obs_addr,
    output logic [DATA_W-1:0] obs_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_PASS,
        S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CW-1:0]     mc_d;
    logic [1:0]        code_d;
    logic [ADDR_W-1:0] oa_d;
    logic [DATA_W-1:0] od_d;

    logic [ADDR_W-1:0] tbl_a [DEPTH];
    logic [DATA_W-1:0] tbl_d [DEPTH];

    logic in_win;
    logic qual;
    logic hit;
    logic [CW-1:0] mc_inc;

    assign in_win = (mem_addr >= win_lo) && (mem_addr <= win_hi);
    assign qual   = mem_we && ((FILTER == 0) || in_win);
    assign hit    = (mem_addr == tbl_a[ptr_q]) && (mem_data == tbl_d[ptr_q]);
    assign mc_inc = match_cnt + CW'(1);

    // Expected table is plain storage; frozen while a check is running.
    always_ff @(posedge clk) begin
        if (tbl_we && state_q != S_ARMED && int'(tbl_idx) < DEPTH) begin
            tbl_a[tbl_idx] <= tbl_addr;
            tbl_d[tbl_idx] <= tbl_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        mc_d    = match_cnt;
        code_d  = fail_code;
        oa_d    = obs_addr;
        od_d    = obs_data;
        unique case (state_q)
            S_ARMED: begin
                if (qual) begin
                    if (hit) begin
                        ptr_d   = ptr_q + IW'(1);
                        mc_d    = mc_inc;
                        timer_d = '0;
                        if (mc_inc == cnt_q)
                            state_d = S_PASS;
                    end else begin
                        oa_d    = mem_addr;
                        od_d    = mem_data;
                        code_d  = 2'b01;
                        state_d = S_FAIL;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    code_d  = 2'b10;
                    state_d = S_FAIL;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                if (start) begin
                    cnt_d   = exp_count;
                    ptr_d   = '0;
                    timer_d = '0;
                    mc_d    = '0;
                    code_d  = 2'b00;
                    oa_d    = '0;
                    od_d    = '0;
                    if (exp_count == '0) begin
                        state_d = S_PASS;
                    end else if (exp_count > CW'(DEPTH)) begin
                        code_d  = 2'b11;
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            timer_q   <= '0;
            match_cnt <= '0;
            fail_code <= 2'b00;
            obs_addr  <= '0;
            obs_data  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            match_cnt <= mc_d;
            fail_code <= code_d;
            obs_addr  <= oa_d;
            obs_data  <= od_d;
        end
    end

    assign busy = (state_q == S_ARMED);
    assign done = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass = (state_q == S_PASS);

endmodule

// File: tb/tb_store_trace_checker.sv
// Bench for store_trace_checker: directed vector table, corner sequences
// and a randomized run against a queue-style reference model.
module tb_store_trace_checker;

    localparam int TO = 16;

    typedef logic [72:0] obs_t;

    typedef struct {
        int          st;
        int          cnt;
        int          tw;
        int          ti;
        logic [31:0] ta;
        logic [31:0] td;
        int          we;
        logic [31:0] a;
        logic [31:0] d;
        obs_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] win_lo;
    logic [31:0] win_hi;
    logic        tbl_we;
    logic [2:0]  tbl_idx;
    logic [31:0] tbl_addr;
    logic [31:0] tbl_data;
    logic [3:0]  exp_count;
    logic        start;

    logic        busy_o [2];
    logic        done_o [2];
    logic        pass_o [2];
    logic [1:0]  code_o [2];
    logic [3:0]  mc_o [2];
    logic [31:0] oa_o [2];
    logic [31:0] od_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    store_trace_checker #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(8), .TIMEOUT(TO), .FILTER(0)
    ) u0 (
        .clk(clk), .reset(reset), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .win_lo(win_lo), .win_hi(win_hi),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .exp_count(exp_count), .start(start),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .fail_code(code_o[0]), .match_cnt(mc_o[0]),
        .obs_addr(oa_o[0]), .obs_data(od_o[0])
    );

    store_trace_checker #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(8), .TIMEOUT(TO), .FILTER(1)
    ) u1 (
        .clk(clk), .reset(reset), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .win_lo(win_lo), .win_hi(win_hi),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .exp_count(exp_count), .start(start),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .fail_code(code_o[1]), .match_cnt(mc_o[1]),
        .obs_addr(oa_o[1]), .obs_data(od_o[1])
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(int b, int dn, int p, int c, int m,
                                logic [31:0] a, logic [31:0] o);
        return {1'(b), 1'(dn), 1'(p), 2'(c), 4'(m), a, o};
    endfunction

    function automatic obs_t got(int k);
        return {busy_o[k], done_o[k], pass_o[k], code_o[k], mc_o[k],
                oa_o[k], od_o[k]};
    endfunction

    function automatic vec_t V(int st, int cnt, int tw, int ti,
                               logic [31:0] ta, logic [31:0] td, int we,
                               logic [31:0] a, logic [31:0] d, obs_t e);
        vec_t v;
        v.st = st; v.cnt = cnt; v.tw = tw; v.ti = ti;
        v.ta = ta; v.td = td; v.we = we; v.a = a; v.d = d; v.e = e;
        return v;
    endfunction

    task automatic chk(string name, int k, obs_t e);
        obs_t g;
        g = got(k);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s u%0d: got bdp=%b code=%0d mc=%0d obs=%h/%h, want bdp=%b code=%0d mc=%0d obs=%h/%h",
                     name, k, g[72:70], g[69:68], g[67:64], g[63:32], g[31:0],
                     e[72:70], e[69:68], e[67:64], e[63:32], e[31:0]);
        end
    endtask

    task automatic idle_in();
        mem_we = 1'b0; mem_addr = '0; mem_data = '0;
        tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
        start = 1'b0; exp_count = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(int idx, logic [31:0] a, logic [31:0] d);
        idle_in();
        tbl_we = 1'b1; tbl_idx = 3'(idx); tbl_addr = a; tbl_data = d;
        tick();
        idle_in();
    endtask

    task automatic do_start(int cnt);
        idle_in();
        start = 1'b1; exp_count = 4'(cnt);
        tick();
        idle_in();
    endtask

    task automatic do_store(logic [31:0] a, logic [31:0] d);
        idle_in();
        mem_we = 1'b1; mem_addr = a; mem_data = d;
        tick();
        idle_in();
    endtask

    // Reference model: an ordered list of expected stores and a count of
    // quiet cycles since the last progress.
    int          m_st [2];
    int          m_cnt [2];
    int          m_mc [2];
    int          m_idle [2];
    int          m_code [2];
    logic [31:0] m_oa [2];
    logic [31:0] m_od [2];
    logic [31:0] m_ta [2][8];
    logic [31:0] m_td [2][8];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_mc[k] = 0; m_idle[k] = 0;
            m_code[k] = 0; m_oa[k] = '0; m_od[k] = '0;
        end
    endtask

    task automatic model_step(int k);
        logic q;
        if (tbl_we && m_st[k] != 1) begin
            m_ta[k][tbl_idx] = tbl_addr;
            m_td[k][tbl_idx] = tbl_data;
        end
        if (start && m_st[k] != 1) begin
            m_mc[k] = 0; m_idle[k] = 0; m_code[k] = 0;
            m_oa[k] = '0; m_od[k] = '0;
            m_cnt[k] = int'(exp_count);
            if (m_cnt[k] == 0) begin
                m_st[k] = 2;
            end else if (m_cnt[k] > 8) begin
                m_st[k] = 3; m_code[k] = 3;
            end else begin
                m_st[k] = 1;
            end
        end else if (m_st[k] == 1) begin
            q = mem_we && (k == 0 || (mem_addr >= win_lo && mem_addr <= win_hi));
            if (q) begin
                if (mem_addr == m_ta[k][m_mc[k]] && mem_data == m_td[k][m_mc[k]]) begin
                    m_mc[k]++;
                    m_idle[k] = 0;
                    if (m_mc[k] == m_cnt[k]) m_st[k] = 2;
                end else begin
                    m_st[k] = 3; m_code[k] = 1;
                    m_oa[k] = mem_addr; m_od[k] = mem_data;
                end
            end else begin
                m_idle[k]++;
                if (m_idle[k] == TO) begin
                    m_st[k] = 3; m_code[k] = 2;
                end
            end
        end
    endtask

    task automatic rcycle();
        tick();
        for (int k = 0; k < 2; k++) begin
            model_step(k);
            chk("random", k,
                mk(m_st[k] == 1, m_st[k] >= 2, m_st[k] == 2, m_code[k],
                   m_mc[k], m_oa[k], m_od[k]));
        end
        idle_in();
    endtask

    vec_t vs [20];
    obs_t z;

    initial begin
        z = mk(0, 0, 0, 0, 0, 0, 0);
        vs[0]  = V(0, 0, 1, 0, 'h64, 'h19, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
        vs[1]  = V(1, 1, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        vs[2]  = V(0, 0, 0, 0, 0, 0, 1, 'h64, 'h19, mk(0, 1, 1, 0, 1, 0, 0));
        vs[3]  = V(0, 0, 1, 0, 'h10, 1, 0, 0, 0, mk(0, 1, 1, 0, 1, 0, 0));
        vs[4]  = V(0, 0, 1, 1, 'h14, 2, 0, 0, 0, mk(0, 1, 1, 0, 1, 0, 0));
        vs[5]  = V(0, 0, 1, 2, 'h18, 3, 0, 0, 0, mk(0, 1, 1, 0, 1, 0, 0));
        vs[6]  = V(1, 3, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        vs[7]  = V(0, 0, 0, 0, 0, 0, 1, 'h10, 1, mk(1, 0, 0, 0, 1, 0, 0));
        vs[8]  = V(0, 0, 0, 0, 0, 0, 1, 'h14, 7, mk(0, 1, 0, 1, 1, 'h14, 7));
        vs[9]  = V(1, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 1, 1, 0, 0, 0, 0));
        vs[10] = V(1, 9, 0, 0, 0, 0, 0, 0, 0, mk(0, 1, 0, 3, 0, 0, 0));
        vs[11] = V(0, 0, 0, 0, 0, 0, 1, 'h18, 3, mk(0, 1, 0, 3, 0, 0, 0));
        vs[12] = V(1, 1, 1, 0, 'h20, 'h55, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        vs[13] = V(0, 0, 0, 0, 0, 0, 1, 'h20, 'h55, mk(0, 1, 1, 0, 1, 0, 0));
        vs[14] = V(1, 1, 0, 0, 0, 0, 1, 'h99, 'h99, mk(1, 0, 0, 0, 0, 0, 0));
        vs[15] = V(0, 0, 0, 0, 0, 0, 1, 'h20, 'h55, mk(0, 1, 1, 0, 1, 0, 0));
        vs[16] = V(1, 3, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
        vs[17] = V(0, 0, 0, 0, 0, 0, 1, 'h20, 'h55, mk(1, 0, 0, 0, 1, 0, 0));
        vs[18] = V(1, 1, 0, 0, 0, 0, 1, 'h14, 2, mk(1, 0, 0, 0, 2, 0, 0));
        vs[19] = V(0, 0, 0, 0, 0, 0, 1, 'h18, 3, mk(0, 1, 1, 0, 3, 0, 0));

        idle_in();
        win_lo = 32'h0;
        win_hi = 32'hFFFF_FFFF;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 0, z);
        chk("reset_state", 1, z);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("idle_after_reset", 0, z);

        for (int i = 0; i < 20; i++) begin
            idle_in();
            start = 1'(vs[i].st); exp_count = 4'(vs[i].cnt);
            tbl_we = 1'(vs[i].tw); tbl_idx = 3'(vs[i].ti);
            tbl_addr = vs[i].ta; tbl_data = vs[i].td;
            mem_we = 1'(vs[i].we); mem_addr = vs[i].a; mem_data = vs[i].d;
            tick();
            chk($sformatf("vec%0d", i), 0, vs[i].e);
            chk($sformatf("vec%0d", i), 1, vs[i].e);
        end
        idle_in();

        // Watchdog after a match: fires on the 16th quiet edge.
        do_wr(0, 'h30, 'hA);
        do_wr(1, 'h34, 'hB);
        do_start(2);
        do_store('h30, 'hA);
        chk("to_first_match", 0, mk(1, 0, 0, 0, 1, 0, 0));
        for (int i = 1; i < TO; i++) begin
            tick();
            chk("to_still_armed", 0, mk(1, 0, 0, 0, 1, 0, 0));
        end
        tick();
        chk("to_expire", 0, mk(0, 1, 0, 2, 1, 0, 0));

        // A store on the expiry edge wins over the watchdog.
        do_start(2);
        do_store('h30, 'hA);
        repeat (TO - 1) tick();
        chk("to_edge_armed", 0, mk(1, 0, 0, 0, 1, 0, 0));
        do_store('h34, 'hB);
        chk("to_edge_store_pass", 0, mk(0, 1, 1, 0, 2, 0, 0));

        // Watchdog counted from arming with no stores at all.
        do_start(2);
        repeat (TO - 1) tick();
        chk("to_arm_armed", 1, mk(1, 0, 0, 0, 0, 0, 0));
        tick();
        chk("to_arm_expire", 1, mk(0, 1, 0, 2, 0, 0, 0));

        // Address window filter, including both inclusive edges.
        do_wr(0, 'h104, 'hAA);
        win_lo = 32'h100;
        win_hi = 32'h1FF;
        do_start(1);
        do_store('h64, 'h19);
        chk("filt_ignored", 1, mk(1, 0, 0, 0, 0, 0, 0));
        chk("nofilt_mismatch", 0, mk(0, 1, 0, 1, 0, 'h64, 'h19));
        do_store('h104, 'hAA);
        chk("filt_pass", 1, mk(0, 1, 1, 0, 1, 0, 0));
        do_wr(0, 'h100, 1);
        do_wr(1, 'h1FF, 2);
        do_start(2);
        do_store('hFF, 1);
        do_store('h200, 2);
        chk("filt_outside", 1, mk(1, 0, 0, 0, 0, 0, 0));
        do_store('h100, 1);
        chk("filt_lo_edge", 1, mk(1, 0, 0, 0, 1, 0, 0));
        do_store('h1FF, 2);
        chk("filt_hi_edge", 1, mk(0, 1, 1, 0, 2, 0, 0));
        win_lo = 32'h0;
        win_hi = 32'hFFFF_FFFF;

        // Table writes while armed are dropped.
        do_wr(0, 'h40, 1);
        do_start(1);
        do_wr(0, 'h44, 2);
        do_store('h40, 1);
        chk("armed_write_ignored", 0, mk(0, 1, 1, 0, 1, 0, 0));

        // Reset mid-check, then re-run on the retained table.
        do_wr(0, 'h50, 5);
        do_wr(1, 'h54, 6);
        do_wr(2, 'h58, 7);
        do_start(3);
        do_store('h50, 5);
        do_store('h54, 6);
        chk("pre_reset_mc2", 0, mk(1, 0, 0, 0, 2, 0, 0));
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", 0, z);
        chk("async_reset", 1, z);
        @(negedge clk);
        reset = 1'b1;
        do_start(3);
        do_store('h50, 5);
        do_store('h54, 6);
        do_store('h58, 7);
        chk("table_retained", 0, mk(0, 1, 1, 0, 3, 0, 0));
        chk("table_retained", 1, mk(0, 1, 1, 0, 3, 0, 0));

        // Randomized run against the reference model.
        win_lo = 32'h100;
        win_hi = 32'h1FF;
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tbl_we = 1'b1; tbl_idx = 3'(i);
            tbl_addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
            tbl_data = 32'($urandom_range(0, 3));
            rcycle();
        end
        begin
            int burst;
            int s;
            burst = 0;
            for (int c = 0; c < 4000; c++) begin
                if (burst > 0) begin
                    burst--;
                end else begin
                    if ($urandom_range(0, 99) < 3) burst = $urandom_range(14, 18);
                    if ((m_st[0] != 1 && m_st[1] != 1 && $urandom_range(0, 3) == 0) ||
                        $urandom_range(0, 49) == 0) begin
                        start = 1'b1;
                        if ($urandom_range(0, 9) == 0)
                            exp_count = 4'($urandom_range(9, 15));
                        else
                            exp_count = 4'($urandom_range(0, 8));
                    end
                    if ($urandom_range(0, 9) == 0) begin
                        tbl_we = 1'b1; tbl_idx = 3'($urandom_range(0, 7));
                        tbl_addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
                        tbl_data = 32'($urandom_range(0, 3));
                    end
                    s = $urandom_range(0, 99);
                    if (s < 55 && m_mc[1] < 8) begin
                        mem_we = 1'b1;
                        mem_addr = m_ta[1][m_mc[1]];
                        mem_data = m_td[1][m_mc[1]];
                    end else if (s < 65) begin
                        mem_we = 1'b1;
                        mem_addr = 32'($urandom_range(0, 'hFF));
                        mem_data = 32'($urandom_range(0, 3));
                    end else if (s < 75) begin
                        mem_we = 1'b1;
                        mem_addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
                        mem_data = 32'($urandom_range(0, 3));
                    end
                end
                rcycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
